// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: control-bundle layout used across the pipeline.
package rv32i_pkg;

  localparam int unsigned CTRL_W = 12;

  localparam int unsigned CTRL_REGWRITE = 0;
  localparam int unsigned CTRL_MEMREAD  = 1;
  localparam int unsigned CTRL_MEMWRITE = 2;
  localparam int unsigned CTRL_MEMTOREG = 3;
  localparam int unsigned CTRL_ALUSRC   = 4;
  localparam int unsigned CTRL_BRANCH   = 5;
  localparam int unsigned CTRL_JUMP     = 6;
  localparam int unsigned CTRL_ALUOP_LO = 7;
  localparam int unsigned CTRL_ALUOP_HI = 10;

  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the ID instruction and a load in EX.
module load_use_detect (
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_addr_i,
  output logic       lu_o
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i);
    rs2_hit = id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i);
    lu_o    = id_valid_i && ex_valid_i && ex_mem_read_i && (ex_rd_addr_i != 5'd0) &&
              (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, memory-stall
// freeze and a saturating bubble counter.
module id_ex_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              id_valid_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [4:0]        id_rs1_addr_i,
  input  logic [4:0]        id_rs2_addr_i,
  input  logic [4:0]        id_rd_addr_i,
  input  logic              id_uses_rs1_i,
  input  logic              id_uses_rs2_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              flush_i,
  input  logic              mem_stall_i,
  output logic              ex_valid_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [XLEN-1:0]   ex_rs1_data_o,
  output logic [XLEN-1:0]   ex_rs2_data_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [4:0]        ex_rs1_addr_o,
  output logic [4:0]        ex_rs2_addr_o,
  output logic [4:0]        ex_rd_addr_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [4:0]        rs1_addr_q, rs1_addr_d;
  logic [4:0]        rs2_addr_q, rs2_addr_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lu;

  load_use_detect u_load_use_detect (
    .id_valid_i    (id_valid_i),
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .id_uses_rs1_i (id_uses_rs1_i),
    .id_uses_rs2_i (id_uses_rs2_i),
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q[CTRL_MEMREAD]),
    .ex_rd_addr_i  (rd_addr_q),
    .lu_o          (lu)
  );

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rd_addr_d  = rd_addr_q;
    ctrl_d     = ctrl_q;
    cnt_d      = cnt_q;

    if (mem_stall_i) begin
      // Freeze: flush and load-use are deferred until memory is ready.
    end else if (flush_i || lu) begin
      valid_d    = 1'b0;
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      rs1_addr_d = '0;
      rs2_addr_d = '0;
      rd_addr_d  = '0;
      ctrl_d     = BUBBLE_CTRL;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      valid_d    = id_valid_i;
      pc_d       = id_pc_i;
      rs1_data_d = id_rs1_data_i;
      rs2_data_d = id_rs2_data_i;
      imm_d      = id_imm_i;
      // An empty ID slot must never look like a forwarding source or a load.
      rs1_addr_d = id_valid_i ? id_rs1_addr_i : 5'd0;
      rs2_addr_d = id_valid_i ? id_rs2_addr_i : 5'd0;
      rd_addr_d  = id_valid_i ? id_rd_addr_i  : 5'd0;
      ctrl_d     = id_valid_i ? id_ctrl_i     : BUBBLE_CTRL;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      ctrl_q     <= BUBBLE_CTRL;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_addr_q  <= rd_addr_d;
      ctrl_q     <= ctrl_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    stall_o       = mem_stall_i || (lu && !flush_i);
    ex_valid_o    = valid_q;
    ex_pc_o       = pc_q;
    ex_rs1_data_o = rs1_data_q;
    ex_rs2_data_o = rs2_data_q;
    ex_imm_o      = imm_q;
    ex_rs1_addr_o = rs1_addr_q;
    ex_rs2_addr_o = rs2_addr_q;
    ex_rd_addr_o  = rd_addr_q;
    ex_ctrl_o     = ctrl_q;
    bubble_cnt_o  = cnt_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage, plus reset-mid-stall and counter saturation.
module tb_id_ex_stage;

  localparam int unsigned CW = 12;
  localparam logic [CW-1:0] C_LW   = 12'h01B;
  localparam logic [CW-1:0] C_ADD  = 12'h101;
  localparam logic [CW-1:0] C_ADDI = 12'h111;
  localparam logic [CW-1:0] C_LUI  = 12'h011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0;
  logic [31:0] id_pc = '0, id_rs1d = '0, id_rs2d = '0, id_imm = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic id_u1 = 1'b0, id_u2 = 1'b0;
  logic [CW-1:0] id_ctrl = '0;
  logic flush = 1'b0, mem_stall = 1'b0;

  logic ex_valid, stall;
  logic [31:0] ex_pc, ex_rs1d, ex_rs2d, ex_imm, cnt;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [CW-1:0] ex_ctrl;

  logic s_valid, s_stall;
  logic [31:0] s_pc, s_rs1d, s_rs2d, s_imm;
  logic [4:0] s_rs1, s_rs2, s_rd;
  logic [CW-1:0] s_ctrl;
  logic [3:0] s_cnt;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_stage u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid), .id_pc_i(id_pc),
    .id_rs1_data_i(id_rs1d), .id_rs2_data_i(id_rs2d), .id_imm_i(id_imm),
    .id_rs1_addr_i(id_rs1), .id_rs2_addr_i(id_rs2), .id_rd_addr_i(id_rd),
    .id_uses_rs1_i(id_u1), .id_uses_rs2_i(id_u2), .id_ctrl_i(id_ctrl),
    .flush_i(flush), .mem_stall_i(mem_stall), .ex_valid_o(ex_valid), .ex_pc_o(ex_pc),
    .ex_rs1_data_o(ex_rs1d), .ex_rs2_data_o(ex_rs2d), .ex_imm_o(ex_imm),
    .ex_rs1_addr_o(ex_rs1), .ex_rs2_addr_o(ex_rs2), .ex_rd_addr_o(ex_rd),
    .ex_ctrl_o(ex_ctrl), .stall_o(stall), .bubble_cnt_o(cnt)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(4)) u_dut_sat (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid), .id_pc_i(id_pc),
    .id_rs1_data_i(id_rs1d), .id_rs2_data_i(id_rs2d), .id_imm_i(id_imm),
    .id_rs1_addr_i(id_rs1), .id_rs2_addr_i(id_rs2), .id_rd_addr_i(id_rd),
    .id_uses_rs1_i(id_u1), .id_uses_rs2_i(id_u2), .id_ctrl_i(id_ctrl),
    .flush_i(flush), .mem_stall_i(mem_stall), .ex_valid_o(s_valid), .ex_pc_o(s_pc),
    .ex_rs1_data_o(s_rs1d), .ex_rs2_data_o(s_rs2d), .ex_imm_o(s_imm),
    .ex_rs1_addr_o(s_rs1), .ex_rs2_addr_o(s_rs2), .ex_rd_addr_o(s_rd),
    .ex_ctrl_o(s_ctrl), .stall_o(s_stall), .bubble_cnt_o(s_cnt)
  );

  typedef struct {
    logic        ms, fl, v;
    logic [31:0] pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2;
    logic [CW-1:0] ctrl;
    logic        e_stall, e_valid;
    logic [31:0] e_pc, e_imm;
    logic [4:0]  e_rs1, e_rd;
    logic [CW-1:0] e_ctrl;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [vec %0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic add_vec(input logic ms, fl, v, input logic [31:0] pc, imm,
                         input logic [4:0] rs1, rs2, rd, input logic u1, u2,
                         input logic [CW-1:0] ctrl, input logic e_stall, e_valid,
                         input logic [31:0] e_pc, e_imm, input logic [4:0] e_rs1, e_rd,
                         input logic [CW-1:0] e_ctrl, input logic [31:0] e_cnt);
    vec_t t;
    t.ms = ms; t.fl = fl; t.v = v; t.pc = pc; t.imm = imm;
    t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.u1 = u1; t.u2 = u2; t.ctrl = ctrl;
    t.e_stall = e_stall; t.e_valid = e_valid; t.e_pc = e_pc; t.e_imm = e_imm;
    t.e_rs1 = e_rs1; t.e_rd = e_rd; t.e_ctrl = e_ctrl; t.e_cnt = e_cnt;
    vecs.push_back(t);
  endtask

  // Operand data is tagged with the PC so that a held or loaded slot is identifiable.
  task automatic drive(input logic ms, fl, v, input logic [31:0] pc, imm,
                       input logic [4:0] rs1, rs2, rd, input logic u1, u2,
                       input logic [CW-1:0] ctrl);
    mem_stall = ms; flush = fl; id_valid = v; id_pc = pc; id_imm = imm;
    id_rs1d = {16'hD100, pc[15:0]}; id_rs2d = {16'hD200, pc[15:0]};
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_u1 = u1; id_u2 = u2; id_ctrl = ctrl;
  endtask

  initial begin
    // ms fl v  pc     imm     rs1 rs2 rd u1 u2 ctrl  | stall valid pc imm rs1 rd ctrl cnt
    add_vec(0,0,1, 32'h10, 32'h7,    0, 0, 5, 1,0, C_ADDI, 0,1, 32'h10, 32'h7,    0,5, C_ADDI, 0);
    add_vec(0,0,1, 32'h14, 32'h0,    1, 0, 5, 1,0, C_LW,   0,1, 32'h14, 32'h0,    1,5, C_LW,   0);
    add_vec(0,0,1, 32'h18, 32'h0,    5, 1, 6, 1,1, C_ADD,  1,0, 32'h0,  32'h0,    0,0, 12'h0,  1);
    add_vec(0,0,1, 32'h18, 32'h0,    5, 1, 6, 1,1, C_ADD,  0,1, 32'h18, 32'h0,    5,6, C_ADD,  1);
    add_vec(0,0,1, 32'h1C, 32'h0,    2, 0, 0, 1,0, C_LW,   0,1, 32'h1C, 32'h0,    2,0, C_LW,   1);
    add_vec(0,0,1, 32'h20, 32'h0,    0, 0, 6, 1,1, C_ADD,  0,1, 32'h20, 32'h0,    0,6, C_ADD,  1);
    add_vec(0,0,1, 32'h24, 32'h0,    1, 0, 5, 1,0, C_LW,   0,1, 32'h24, 32'h0,    1,5, C_LW,   1);
    add_vec(0,0,1, 32'h28, 32'h1000, 5, 0, 5, 0,0, C_LUI,  0,1, 32'h28, 32'h1000, 5,5, C_LUI,  1);
    add_vec(0,0,1, 32'h2C, 32'h0,    5, 0, 7, 1,0, C_LW,   0,1, 32'h2C, 32'h0,    5,7, C_LW,   1);
    add_vec(0,1,1, 32'h30, 32'h0,    7, 7, 8, 1,1, C_ADD,  0,0, 32'h0,  32'h0,    0,0, 12'h0,  2);
    add_vec(0,0,0, 32'h34, 32'h9,    3, 0, 9, 1,0, C_ADD,  0,0, 32'h34, 32'h9,    0,0, 12'h0,  2);
    add_vec(0,0,1, 32'h38, 32'h0,    1, 0, 5, 1,0, C_LW,   0,1, 32'h38, 32'h0,    1,5, C_LW,   2);
    for (int i = 0; i < 3; i++)
      add_vec(1,1,1, 32'h3C, 32'h0,  5, 5, 6, 1,1, C_ADD,  1,1, 32'h38, 32'h0,    1,5, C_LW,   2);
    add_vec(0,1,1, 32'h3C, 32'h0,    5, 5, 6, 1,1, C_ADD,  0,0, 32'h0,  32'h0,    0,0, 12'h0,  3);
    add_vec(0,0,1, 32'h40, 32'h0,    1, 0, 5, 1,0, C_LW,   0,1, 32'h40, 32'h0,    1,5, C_LW,   3);
    add_vec(0,0,1, 32'h44, 32'h4,    5, 0, 5, 1,0, C_LW,   1,0, 32'h0,  32'h0,    0,0, 12'h0,  4);
    add_vec(0,0,1, 32'h44, 32'h4,    5, 0, 5, 1,0, C_LW,   0,1, 32'h44, 32'h4,    5,5, C_LW,   4);
    add_vec(0,0,1, 32'h48, 32'h0,    5, 0, 6, 1,1, C_ADD,  1,0, 32'h0,  32'h0,    0,0, 12'h0,  5);
    add_vec(0,0,1, 32'h48, 32'h0,    5, 0, 6, 1,1, C_ADD,  0,1, 32'h48, 32'h0,    5,6, C_ADD,  5);

    // Reset state
    #2;
    chk("rst_valid", -1, {31'd0, ex_valid}, 32'd0);
    chk("rst_pc", -1, ex_pc, 32'd0);
    chk("rst_data", -1, ex_rs1d | ex_rs2d | ex_imm, 32'd0);
    chk("rst_addr", -1, {17'd0, ex_rs1, ex_rs2, ex_rd}, 32'd0);
    chk("rst_ctrl", -1, {20'd0, ex_ctrl}, 32'd0);
    chk("rst_cnt", -1, cnt, 32'd0);
    chk("rst_stall", -1, {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].ms, vecs[i].fl, vecs[i].v, vecs[i].pc, vecs[i].imm, vecs[i].rs1,
            vecs[i].rs2, vecs[i].rd, vecs[i].u1, vecs[i].u2, vecs[i].ctrl);
      #1;
      chk("stall", i, {31'd0, stall}, {31'd0, vecs[i].e_stall});
      @(posedge clk);
      #1;
      chk("ex_valid", i, {31'd0, ex_valid}, {31'd0, vecs[i].e_valid});
      chk("ex_pc", i, ex_pc, vecs[i].e_pc);
      chk("ex_imm", i, ex_imm, vecs[i].e_imm);
      chk("ex_rs1_data", i, ex_rs1d,
          (vecs[i].e_pc == 0) ? 32'd0 : {16'hD100, vecs[i].e_pc[15:0]});
      chk("ex_rs2_data", i, ex_rs2d,
          (vecs[i].e_pc == 0) ? 32'd0 : {16'hD200, vecs[i].e_pc[15:0]});
      chk("ex_rs1_addr", i, {27'd0, ex_rs1}, {27'd0, vecs[i].e_rs1});
      chk("ex_rd_addr", i, {27'd0, ex_rd}, {27'd0, vecs[i].e_rd});
      chk("ex_ctrl", i, {20'd0, ex_ctrl}, {20'd0, vecs[i].e_ctrl});
      chk("bubble_cnt", i, cnt, vecs[i].e_cnt);
      chk("sat_cnt_track", i, {28'd0, s_cnt}, {28'd0, vecs[i].e_cnt[3:0]});
    end

    // Reset asserted while a load-use stall is being raised
    @(negedge clk);
    drive(0,0,1, 32'h50, 32'h0, 1, 0, 5, 1,0, C_LW);
    @(negedge clk);
    drive(0,0,1, 32'h54, 32'h0, 5, 0, 6, 1,1, C_ADD);
    #1;
    chk("pre_rst_stall", 100, {31'd0, stall}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 100, {31'd0, ex_valid}, 32'd0);
    chk("mid_rst_rd", 100, {27'd0, ex_rd}, 32'd0);
    chk("mid_rst_cnt", 100, cnt, 32'd0);
    chk("mid_rst_stall", 100, {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Counter saturation: 20 consecutive flush bubbles
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(0,1,1, 32'h60 + 32'(4*k), 32'h0, 1, 2, 3, 1,1, C_ADD);
      @(posedge clk);
      #1;
      if (k == 13) chk("sat_cnt_14", 200, {28'd0, s_cnt}, 32'hE);
      if (k == 14) chk("sat_cnt_15", 200, {28'd0, s_cnt}, 32'hF);
    end
    chk("sat_cnt_final", 200, {28'd0, s_cnt}, 32'hF);
    chk("wide_cnt_final", 200, cnt, 32'd20);
    chk("sat_ex_valid", 200, {31'd0, s_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
